// File: rtl/key_cmd_pkg.sv
// Shared key codes, move encodings and controller state for the keypad cursor block.
package key_cmd_pkg;

    localparam logic [3:0] KEY_UP    = 4'h1;
    localparam logic [3:0] KEY_DOWN  = 4'h9;
    localparam logic [3:0] KEY_LEFT  = 4'h4;
    localparam logic [3:0] KEY_RIGHT = 4'h6;
    localparam logic [3:0] KEY_PLACE = 4'h5;
    localparam logic [3:0] KEY_PASS  = 4'hF;
    localparam logic [3:0] KEY_UNDO  = 4'hE;

    // 2'b11 is reserved and never produced.
    localparam logic [1:0] MOVE_PLACE = 2'b00;
    localparam logic [1:0] MOVE_PASS  = 2'b01;
    localparam logic [1:0] MOVE_UNDO  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/coord_wrap_step.sv
// Combinational +1/-1 on one board coordinate with modulo BOARD_SIZE wrap.
module coord_wrap_step #(
    parameter int BOARD_SIZE = 19,
    parameter int COORD_W    = 5
) (
    input  logic [COORD_W-1:0] coord_i,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [COORD_W-1:0] coord_o
);

    localparam logic [COORD_W:0]   LAST_W = (COORD_W+1)'(BOARD_SIZE - 1);
    localparam logic [COORD_W-1:0] LAST_C = COORD_W'(BOARD_SIZE - 1);

    logic [COORD_W:0] wide;
    logic [COORD_W:0] plus_one;
    logic [COORD_W:0] minus_one;

    // One extra bit lets the decrement borrow show up as the MSB.
    assign wide      = {1'b0, coord_i};
    assign plus_one  = wide + 1'b1;
    assign minus_one = wide - 1'b1;

    always_comb begin
        coord_o = coord_i;
        if (inc_i) begin
            coord_o = (plus_one > LAST_W) ? '0 : plus_one[COORD_W-1:0];
        end else if (dec_i) begin
            coord_o = minus_one[COORD_W] ? LAST_C : minus_one[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/key_cursor_ctrl.sv
// Turns keypad key events into cursor motion and place/pass/undo move commands.
module key_cursor_ctrl
    import key_cmd_pkg::*;
#(
    parameter int BOARD_SIZE = 19,
    parameter int COORD_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [3:0]         key_index,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               armed,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [1:0]         move_kind,
    output logic [COORD_W-1:0] move_x,
    output logic [COORD_W-1:0] move_y
);

    localparam logic [COORD_W-1:0] CENTER = COORD_W'(BOARD_SIZE / 2);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic               armed_q, armed_d;
    logic [1:0]         kind_q, kind_d;
    logic [COORD_W-1:0] mx_q, mx_d;
    logic [COORD_W-1:0] my_q, my_d;

    logic               key_accept;
    logic [COORD_W-1:0] x_step;
    logic [COORD_W-1:0] y_step;

    coord_wrap_step #(
        .BOARD_SIZE (BOARD_SIZE),
        .COORD_W    (COORD_W)
    ) u_x_step (
        .coord_i (cx_q),
        .inc_i   (key_index == KEY_RIGHT),
        .dec_i   (key_index == KEY_LEFT),
        .coord_o (x_step)
    );

    coord_wrap_step #(
        .BOARD_SIZE (BOARD_SIZE),
        .COORD_W    (COORD_W)
    ) u_y_step (
        .coord_i (cy_q),
        .inc_i   (key_index == KEY_DOWN),
        .dec_i   (key_index == KEY_UP),
        .coord_o (y_step)
    );

    // Ready comes from state alone so the scanner sees no combinational path back.
    assign key_ready  = (state_q == IDLE);
    assign key_accept = key_valid && key_ready;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        armed_d = armed_q;
        kind_d  = kind_q;
        mx_d    = mx_q;
        my_d    = my_q;
        case (state_q)
            IDLE: begin
                // With en low the key is still consumed, just without effect.
                if (key_accept && en) begin
                    case (key_index)
                        KEY_UP, KEY_DOWN: begin
                            cy_d    = y_step;
                            armed_d = 1'b0;
                        end
                        KEY_LEFT, KEY_RIGHT: begin
                            cx_d    = x_step;
                            armed_d = 1'b0;
                        end
                        KEY_PLACE: begin
                            if (armed_q) begin
                                state_d = EMIT;
                                kind_d  = MOVE_PLACE;
                                mx_d    = cx_q;
                                my_d    = cy_q;
                                armed_d = 1'b0;
                            end else begin
                                armed_d = 1'b1;
                            end
                        end
                        KEY_PASS: begin
                            state_d = EMIT;
                            kind_d  = MOVE_PASS;
                            mx_d    = '0;
                            my_d    = '0;
                            armed_d = 1'b0;
                        end
                        KEY_UNDO: begin
                            state_d = EMIT;
                            kind_d  = MOVE_UNDO;
                            mx_d    = '0;
                            my_d    = '0;
                            armed_d = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            EMIT: begin
                if (move_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= CENTER;
            cy_q    <= CENTER;
            armed_q <= 1'b0;
            kind_q  <= MOVE_PLACE;
            mx_q    <= '0;
            my_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            armed_q <= armed_d;
            kind_q  <= kind_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
        end
    end

    assign cursor_x   = cx_q;
    assign cursor_y   = cy_q;
    assign armed      = armed_q;
    assign move_valid = (state_q == EMIT);
    assign move_kind  = kind_q;
    assign move_x     = mx_q;
    assign move_y     = my_q;

endmodule
